kbd_seq_capture: RTL
====================

Name: kbd_seq_capture

Overview:
- Parametrised successor to the single-key keyboard front-end.
- Consumes PS/2 scan-code bytes (ready strobe from the PS/2 receiver) and filters break and extended sequences.
- After a 'W' arm key, collects up to DEPTH decimal digit keys into a buffer, with backspace and escape editing; commits the whole sequence on Enter.
- Sits between the PS/2 receiver and the programming/control FSMs; replaces one-key capture with multi-digit entry.

Parameters:
- DEPTH, 4, maximum digits held per sequence (1..8).
- DIG_W, 4, width of one decoded digit (values 0..9).
- LEN_W, 3, width of seq_len; must satisfy 2**LEN_W > DEPTH.
- TIMEOUT_CYC, 50_000_000, idle cycles in ARMED before auto-abort (used only with KBD_TIMEOUT_EN).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- enable, in, 1, block enable; low forces IDLE and clears the buffer.
- rx_cod, in, 1, one-cycle strobe: data holds a new scan-code byte.
- data, in, 8, scan-code byte.
- armed, out, 1, high while in ARMED.
- seq_valid, out, 1, one-cycle pulse on commit.
- seq_len, out, LEN_W, digits in the committed sequence (0..DEPTH).
- seq_data, out, DEPTH*DIG_W, committed digits; first-entered digit in [DIG_W-1:0]; unused slots are 0.
- ovf, out, 1, sticky: a digit was dropped because the buffer was full; cleared on arm.
- abort, out, 1, one-cycle pulse on ESC or timeout.

Behaviour:
- Reset (rst=0 at clk edge):
  - State IDLE; buffer, count and prefix flags cleared.
  - All outputs 0: armed, seq_valid, seq_len, seq_data, ovf, abort.
- Byte filter (all states, acts only when rx_cod=1):
  - 0xE0 sets ext; 0xF0 sets brk.
  - Any other byte with ext|brk set is discarded, and both flags clear.
  - Otherwise the byte is a "make" key and goes to the FSM in the same cycle.
  - E0 F0 xx is therefore fully discarded.
- Key map:
  - Digits: 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9.
  - Controls: 0x1D W, 0x5A ENTER, 0x66 BKSP, 0x76 ESC.
  - All other make keys are ignored.
- FSM states: IDLE, ARMED, COMMIT.
  - IDLE:
    - make W → ARMED; count=0, buffer=0, ovf=0.
    - Any other key is ignored.
  - ARMED:
    - Digit with count<DEPTH → slot[count]=digit, count+1.
    - Digit with count==DEPTH → digit dropped, ovf=1.
    - BKSP with count>0 → count-1, slot zeroed. BKSP with count==0 → no-op.
    - ENTER → COMMIT.
    - ESC → IDLE, abort pulse; committed outputs unchanged.
    - W → restart: count=0, ovf=0.
  - COMMIT (exactly one cycle):
    - seq_data, seq_len and seq_valid are registered; they appear the cycle after entering COMMIT, i.e. 2 cycles after the ENTER strobe.
    - Next state IDLE.
    - A byte arriving in this cycle updates the prefix flags only; a make key is dropped.
- seq_data and seq_len hold until the next commit or reset; ENTER with count=0 commits seq_len=0.
- armed is a registered decode of state==ARMED.
- enable=0: next cycle state=IDLE, buffer/count/flags cleared, no pulses; seq_data, seq_len and ovf are retained.
- Reset mid-entry discards the partial sequence.

Optional Feature:
- Macro: KBD_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) resets on arm and on every rx_cod while ARMED.
  - When it reaches TIMEOUT_CYC, the block goes to IDLE and pulses abort for one cycle.
  - Any partial digits are discarded.
- Undefined: no counter is synthesised; ARMED persists indefinitely.

Decomposition:
- Package kbd_pkg:
  - Scan-code localparams: SC_E0, SC_F0, SC_W, SC_ENTER, SC_BKSP, SC_ESC, and the ten digit codes.
  - State enum: IDLE, ARMED, COMMIT.
  - DIG_W default.
- Sub-module kbd_digit_lut (combinational):
  - data[7:0] → is_digit, digit[DIG_W-1:0].
  - Also flags is_w, is_enter, is_bksp, is_esc.
- The top level holds the filter, FSM, buffer and optional timer.

Test Plan:
- Arm and commit: bytes 1D, F0 1D, 16, F0 16, 1E, 26, 5A → seq_valid once; seq_len=3; seq_data[11:0]=0x321; upper nibble 0; armed=0 afterwards.
- Overflow and backspace (DEPTH=4): 1D, then 16 1E 26 25 2E, then 66, then 46, then 5A.
  - After 2E: ovf=1.
  - Final: seq_len=4, seq_data=0x9321, ovf=1.
- Filtering: in IDLE, F0 1D → stays IDLE. In ARMED, E0 16 and F0 1E → no digits stored; following 5A → seq_len=0.
- Abort: 1D 16 76 → abort pulse 1 cycle, state IDLE, seq_data unchanged from the previous commit.
- Reset/enable: enable=0 mid-entry → IDLE next cycle. rst=0 → all outputs 0 at the next edge, including after a commit.
- With KBD_TIMEOUT_EN and TIMEOUT_CYC=20: 1D then silence → abort pulse 20 cycles after the last strobe. A byte at cycle 19 restarts the count.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan codes, FSM state type and default widths for the multi-digit keyboard capture.
package kbd_pkg;

  localparam int unsigned DIG_W_DEFAULT = 4;

  // Prefix bytes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;

  // Control keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Digit keys (main row)
  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCommit
  } kbd_state_e;

endpackage

// File: rtl/kbd_digit_lut.sv
// Combinational decode of a make-code byte into a digit value and control-key flags.
module kbd_digit_lut
  import kbd_pkg::*;
#(
  parameter int unsigned DIG_W = DIG_W_DEFAULT
) (
  input  logic [7:0]       data_i,
  output logic             is_digit_o,
  output logic [DIG_W-1:0] digit_o,
  output logic             is_w_o,
  output logic             is_enter_o,
  output logic             is_bksp_o,
  output logic             is_esc_o
);

  always_comb begin
    is_digit_o = 1'b1;
    digit_o    = '0;
    case (data_i)
      SC_D0:   digit_o = DIG_W'(0);
      SC_D1:   digit_o = DIG_W'(1);
      SC_D2:   digit_o = DIG_W'(2);
      SC_D3:   digit_o = DIG_W'(3);
      SC_D4:   digit_o = DIG_W'(4);
      SC_D5:   digit_o = DIG_W'(5);
      SC_D6:   digit_o = DIG_W'(6);
      SC_D7:   digit_o = DIG_W'(7);
      SC_D8:   digit_o = DIG_W'(8);
      SC_D9:   digit_o = DIG_W'(9);
      default: is_digit_o = 1'b0;
    endcase
  end

  assign is_w_o     = (data_i == SC_W);
  assign is_enter_o = (data_i == SC_ENTER);
  assign is_bksp_o  = (data_i == SC_BKSP);
  assign is_esc_o   = (data_i == SC_ESC);

endmodule

// File: rtl/kbd_seq_capture.sv
// PS/2 multi-digit sequence capture: break/extended filter, W-armed digit buffer with editing.
// Optional idle auto-abort timer in ARMED is built when KBD_TIMEOUT_EN is defined.
module kbd_seq_capture
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DIG_W       = DIG_W_DEFAULT,
  parameter int unsigned LEN_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   rx_cod,
  input  logic [7:0]             data,
  output logic                   armed,
  output logic                   seq_valid,
  output logic [LEN_W-1:0]       seq_len,
  output logic [DEPTH*DIG_W-1:0] seq_data,
  output logic                   ovf,
  output logic                   abort
);

  if (DEPTH < 1 || DEPTH > 8 || (1 << LEN_W) <= DEPTH || TIMEOUT_CYC < 1) begin : g_param_err
    $error("kbd_seq_capture: illegal parameter combination");
  end

  logic             is_digit, is_w, is_enter, is_bksp, is_esc;
  logic [DIG_W-1:0] digit;

  kbd_digit_lut #(
    .DIG_W (DIG_W)
  ) u_lut (
    .data_i     (data),
    .is_digit_o (is_digit),
    .digit_o    (digit),
    .is_w_o     (is_w),
    .is_enter_o (is_enter),
    .is_bksp_o  (is_bksp),
    .is_esc_o   (is_esc)
  );

  kbd_state_e                  state_q, state_d;
  logic                        ext_q, ext_d;
  logic                        brk_q, brk_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [DEPTH-1:0][DIG_W-1:0] buf_q, buf_d;
  logic [DEPTH-1:0][DIG_W-1:0] seq_data_q, seq_data_d;
  logic [LEN_W-1:0]            seq_len_q, seq_len_d;
  logic                        seq_valid_q, seq_valid_d;
  logic                        ovf_q, ovf_d;
  logic                        abort_q, abort_d;
  logic                        armed_q, armed_d;
  logic                        make;

`ifdef KBD_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
  logic [TmrW-1:0] tmr_q, tmr_d;
`endif

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    make        = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    seq_data_d  = seq_data_q;
    seq_len_d   = seq_len_q;
    seq_valid_d = 1'b0;
    ovf_d       = ovf_q;
    abort_d     = 1'b0;

    // Prefix filter: the byte after E0 or F0 is swallowed and clears both flags.
    if (rx_cod) begin
      if (data == SC_E0) begin
        ext_d = 1'b1;
      end else if (data == SC_F0) begin
        brk_d = 1'b1;
      end else if (ext_q || brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        make = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (make && is_w) begin
          state_d = StArmed;
          cnt_d   = '0;
          buf_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StArmed: begin
        if (make) begin
          if (is_digit) begin
            if (cnt_q < LEN_W'(DEPTH)) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (LEN_W'(i) == cnt_q) buf_d[i] = digit;
              end
              cnt_d = cnt_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (is_bksp) begin
            if (cnt_q != '0) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (LEN_W'(i) == cnt_q - LEN_W'(1)) buf_d[i] = '0;
              end
              cnt_d = cnt_q - LEN_W'(1);
            end
          end else if (is_enter) begin
            state_d = StCommit;
          end else if (is_esc) begin
            state_d = StIdle;
            abort_d = 1'b1;
            cnt_d   = '0;
            buf_d   = '0;
          end else if (is_w) begin
            cnt_d = '0;
            buf_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      StCommit: begin
        seq_valid_d = 1'b1;
        seq_len_d   = cnt_q;
        seq_data_d  = buf_q;
        state_d     = StIdle;
        cnt_d       = '0;
        buf_d       = '0;
      end
      default: state_d = StIdle;
    endcase

`ifdef KBD_TIMEOUT_EN
    // Counts idle cycles since the arm or the most recent byte strobe.
    tmr_d = '0;
    if (state_q == StArmed && state_d == StArmed && !rx_cod) begin
      if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        abort_d = 1'b1;
        cnt_d   = '0;
        buf_d   = '0;
      end else begin
        tmr_d = tmr_q + TmrW'(1);
      end
    end
`endif

    if (!enable) begin
      state_d     = StIdle;
      cnt_d       = '0;
      buf_d       = '0;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      seq_valid_d = 1'b0;
      abort_d     = 1'b0;
      seq_data_d  = seq_data_q;
      seq_len_d   = seq_len_q;
`ifdef KBD_TIMEOUT_EN
      tmr_d       = '0;
`endif
    end

    armed_d = (state_d == StArmed);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      cnt_q       <= '0;
      buf_q       <= '0;
      seq_data_q  <= '0;
      seq_len_q   <= '0;
      seq_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      abort_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      seq_data_q  <= seq_data_d;
      seq_len_q   <= seq_len_d;
      seq_valid_q <= seq_valid_d;
      ovf_q       <= ovf_d;
      abort_q     <= abort_d;
      armed_q     <= armed_d;
    end
  end

`ifdef KBD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`endif

  assign armed     = armed_q;
  assign seq_valid = seq_valid_q;
  assign seq_len   = seq_len_q;
  assign seq_data  = seq_data_q;
  assign ovf       = ovf_q;
  assign abort     = abort_q;

endmodule
